// File: rtl/shot_ctrl.sv
// shot_ctrl: shot-clock controller for a two-team game.
//
// A possession runs a countdown from SHOT_TIME, stepping once every TICK_DIV
// clocks. The possessing team may shoot; a made shot scores and possession
// flips. If the countdown expires, buzz is held for BUZZ_LEN clocks and
// possession flips.
//
// Optional feature: define SHOT_CTRL_WIN_EN to end the game in DONE once a
// team's score reaches 9.
//
// Ports:
//   clk      in   system clock, rising edge
//   nrst     in   asynchronous active-low reset
//   start    in   begin play from IDLE
//   stop     in   return to IDLE from any state (highest priority)
//   shoot_a  in   team A shot request
//   shoot_b  in   team B shot request
//   hit      in   shot result, sampled in SHOT
//   count    out  remaining shot-clock value
//   shoot    out  one-cycle pulse while in SHOT
//   buzz     out  high in BUZZ (and DONE)
//   poss     out  possession, 0 = team A, 1 = team B
//   score_a  out  team A score (saturating)
//   score_b  out  team B score (saturating)
//   busy     out  high in every state except IDLE
//
// state | meaning
// IDLE  | waiting for start, outputs cleared
// RUN   | countdown active, watching the possessor's request
// SHOT  | one-cycle shot, hit sampled here
// BUZZ  | countdown expired, buzz held BUZZ_LEN cycles
// DONE  | game won (SHOT_CTRL_WIN_EN only), buzz held until stop
module shot_ctrl #(
  parameter logic [3:0] SHOT_TIME = 4'd10,
  parameter int         TICK_DIV  = 4,
  parameter int         BUZZ_LEN  = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       stop,
  input  logic       shoot_a,
  input  logic       shoot_b,
  input  logic       hit,
  output logic [3:0] count,
  output logic       shoot,
  output logic       buzz,
  output logic       poss,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SHOT,
    S_BUZZ
`ifdef SHOT_CTRL_WIN_EN
    , S_DONE
`endif
  } state_t;

  localparam logic [3:0] DIV_LAST  = 4'(TICK_DIV - 1);
  localparam logic [3:0] BUZZ_LAST = 4'(BUZZ_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] div_q, div_d;
  logic [3:0] buzz_cnt_q, buzz_cnt_d;
  logic       poss_q, poss_d;
  logic [3:0] score_a_q, score_a_d;
  logic [3:0] score_b_q, score_b_d;
  logic       shoot_q, shoot_d;
  logic       buzz_q, buzz_d;
  logic       busy_q, busy_d;

  logic       req;

  // Only the possessor's request counts.
  assign req = poss_q ? shoot_b : shoot_a;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    div_d      = div_q;
    buzz_cnt_d = buzz_cnt_q;
    poss_d     = poss_q;
    score_a_d  = score_a_q;
    score_b_d  = score_b_q;
    shoot_d    = 1'b0;
    buzz_d     = 1'b0;

    if (stop) begin
      state_d    = S_IDLE;
      count_d    = 4'd0;
      div_d      = 4'd0;
      buzz_cnt_d = 4'd0;
      poss_d     = 1'b0;
      score_a_d  = 4'd0;
      score_b_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RUN;
            count_d   = SHOT_TIME;
            div_d     = 4'd0;
            poss_d    = 1'b0;
            score_a_d = 4'd0;
            score_b_d = 4'd0;
          end
        end

        S_RUN: begin
          // A shot beats an expiry tick in the same cycle.
          if (req) begin
            state_d = S_SHOT;
            shoot_d = 1'b1;
          end else if (div_q == DIV_LAST) begin
            div_d = 4'd0;
            if (count_q == 4'd0) begin
              state_d    = S_BUZZ;
              buzz_d     = 1'b1;
              buzz_cnt_d = BUZZ_LAST;
            end else begin
              count_d = count_q - 4'd1;
            end
          end else begin
            div_d = div_q + 4'd1;
          end
        end

        S_SHOT: begin
          if (hit) begin
            if (!poss_q) begin
              if (score_a_q != 4'd15) score_a_d = score_a_q + 4'd1;
            end else begin
              if (score_b_q != 4'd15) score_b_d = score_b_q + 4'd1;
            end
          end
          state_d = S_RUN;
          poss_d  = ~poss_q;
          count_d = SHOT_TIME;
          div_d   = 4'd0;
`ifdef SHOT_CTRL_WIN_EN
          if (hit && ((!poss_q && score_a_q == 4'd8) ||
                      ( poss_q && score_b_q == 4'd8))) begin
            state_d = S_DONE;
            poss_d  = poss_q;
            count_d = 4'd0;
            buzz_d  = 1'b1;
          end
`endif
        end

        S_BUZZ: begin
          if (buzz_cnt_q == 4'd0) begin
            state_d = S_RUN;
            poss_d  = ~poss_q;
            count_d = SHOT_TIME;
            div_d   = 4'd0;
          end else begin
            buzz_cnt_d = buzz_cnt_q - 4'd1;
            buzz_d     = 1'b1;
          end
        end

`ifdef SHOT_CTRL_WIN_EN
        S_DONE: begin
          buzz_d  = 1'b1;
          count_d = 4'd0;
        end
`endif

        default: begin
          state_d = S_IDLE;
          count_d = 4'd0;
          div_d   = 4'd0;
          poss_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      count_q    <= 4'd0;
      div_q      <= 4'd0;
      buzz_cnt_q <= 4'd0;
      poss_q     <= 1'b0;
      score_a_q  <= 4'd0;
      score_b_q  <= 4'd0;
      shoot_q    <= 1'b0;
      buzz_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      buzz_cnt_q <= buzz_cnt_d;
      poss_q     <= poss_d;
      score_a_q  <= score_a_d;
      score_b_q  <= score_b_d;
      shoot_q    <= shoot_d;
      buzz_q     <= buzz_d;
      busy_q     <= busy_d;
    end
  end

  assign count   = count_q;
  assign shoot   = shoot_q;
  assign buzz    = buzz_q;
  assign poss    = poss_q;
  assign score_a = score_a_q;
  assign score_b = score_b_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_shot_ctrl.sv
// Testbench for shot_ctrl: directed scenarios plus a randomized run checked
// against a timeline model (possession elapsed time -> count/buzz).
module tb_shot_ctrl;

  localparam int ST  = 10;
  localparam int TD  = 4;
  localparam int BL  = 3;
  localparam int EXP = (ST + 1) * TD;  // elapsed cycles at which buzz begins
`ifdef SHOT_CTRL_WIN_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, shoot_a = 1'b0, shoot_b = 1'b0, hit = 1'b0;
  logic [3:0] count, score_a, score_b;
  logic       shoot, buzz, poss, busy;

  int checks = 0;
  int failures = 0;

  shot_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .stop(stop),
    .shoot_a(shoot_a), .shoot_b(shoot_b), .hit(hit),
    .count(count), .shoot(shoot), .buzz(buzz), .poss(poss),
    .score_a(score_a), .score_b(score_b), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic       m_active, m_shot, m_done, m_poss;
  int         m_t;
  logic [3:0] m_sa, m_sb, m_held;

  function automatic logic [3:0] cnt_at(input int t);
    if (t >= EXP) return 4'd0;
    return 4'(ST - t / TD);
  endfunction

  task model_reset();
    m_active = 0; m_shot = 0; m_done = 0; m_poss = 0;
    m_t = 0; m_sa = 0; m_sb = 0; m_held = 0;
  endtask

  task model_step(input logic st, input logic sp, input logic sa,
                  input logic sb, input logic h);
    if (sp) model_reset();
    else if (!m_active) begin
      if (st) begin
        m_active = 1; m_t = 0; m_poss = 0; m_sa = 0; m_sb = 0;
      end
    end else if (m_done) begin
      m_done = 1;
    end else if (m_shot) begin
      m_shot = 0;
      if (h) begin
        if (!m_poss) begin if (m_sa < 15) m_sa = m_sa + 1; end
        else         begin if (m_sb < 15) m_sb = m_sb + 1; end
      end
      if (WIN && h && ((!m_poss && m_sa == 9) || (m_poss && m_sb == 9)))
        m_done = 1;
      else begin
        m_poss = !m_poss; m_t = 0;
      end
    end else if (m_t < EXP && (m_poss ? sb : sa)) begin
      m_shot = 1; m_held = cnt_at(m_t);
    end else begin
      m_t = m_t + 1;
      if (m_t == EXP + BL) begin
        m_poss = !m_poss; m_t = 0;
      end
    end
  endtask

  // Drive one clock cycle; outputs are stable 1 time unit after the edge.
  task cycle(input logic st, input logic sp, input logic sa,
             input logic sb, input logic h);
    start = st; stop = sp; shoot_a = sa; shoot_b = sb; hit = h;
    @(posedge clk);
    model_step(st, sp, sa, sb, h);
    #1;
  endtask

  task idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task test_reset();
    nrst = 1'b0;
    model_reset();
    #2;
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({shoot, buzz, poss} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {shoot, buzz, poss}); end
    checks++; if ({score_a, score_b} !== 8'd0) begin failures++; $display("FAIL reset_scores got=%h exp=00", {score_a, score_b}); end
    #10 nrst = 1'b1;
    idle(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_stays_idle got=%b exp=0", busy); end
  endtask

  task test_countdown();
    int rise, blen;
    rise = -1; blen = 0;
    cycle(1, 0, 0, 0, 0);
    checks++; if (count !== 4'd10) begin failures++; $display("FAIL cd_entry_count got=%0d exp=10", count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cd_entry_busy got=%b exp=1", busy); end
    for (int n = 1; n <= 47; n++) begin
      cycle(0, 0, 0, 0, 0);
      if (n < 44) begin
        checks++;
        if (count !== 4'(10 - n / 4)) begin failures++; $display("FAIL cd_count n=%0d got=%0d exp=%0d", n, count, 10 - n / 4); end
      end
      if (buzz === 1'b1 && rise < 0) rise = n;
      if (buzz === 1'b1) blen++;
    end
    checks++; if (rise !== 44) begin failures++; $display("FAIL cd_buzz_rise got=%0d exp=44", rise); end
    checks++; if (blen !== 3) begin failures++; $display("FAIL cd_buzz_len got=%0d exp=3", blen); end
    checks++; if (poss !== 1'b1) begin failures++; $display("FAIL cd_poss got=%b exp=1", poss); end
    checks++; if (count !== 4'd10) begin failures++; $display("FAIL cd_reload got=%0d exp=10", count); end
    cycle(0, 1, 0, 0, 0);
  endtask

  task test_shot();
    cycle(1, 0, 0, 0, 0);
    idle(12);
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL sh_pre_count got=%0d exp=7", count); end
    cycle(0, 0, 1, 1, 1);
    checks++; if (shoot !== 1'b1) begin failures++; $display("FAIL sh_pulse got=%b exp=1", shoot); end
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL sh_hold got=%0d exp=7", count); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (shoot !== 1'b0) begin failures++; $display("FAIL sh_one_cycle got=%b exp=0", shoot); end
    checks++; if (score_a !== 4'd1 || score_b !== 4'd0) begin failures++; $display("FAIL sh_score got=%0d/%0d exp=1/0", score_a, score_b); end
    checks++; if (poss !== 1'b1 || count !== 4'd10) begin failures++; $display("FAIL sh_flip got=%b/%0d exp=1/10", poss, count); end
    // shoot_a held while team B possesses: ignored
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++; if (shoot !== 1'b0) begin failures++; $display("FAIL sh_nonposs got=%b exp=0", shoot); end
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    checks++; if (poss !== 1'b0 || shoot !== 1'b0) begin failures++; $display("FAIL sh_b_done got=%b/%b exp=0/0", poss, shoot); end
    // held shoot_a belongs to the new possessor: fires on first RUN cycle
    cycle(0, 0, 1, 0, 0);
    checks++; if (shoot !== 1'b1) begin failures++; $display("FAIL sh_held_refire got=%b exp=1", shoot); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (poss !== 1'b1 || score_a !== 4'd1) begin failures++; $display("FAIL sh_miss got=%b/%0d exp=1/1", poss, score_a); end
    cycle(0, 1, 0, 0, 0);
  endtask

  task test_expiry_race();
    cycle(1, 0, 0, 0, 0);
    idle(43);
    checks++; if (count !== 4'd0 || buzz !== 1'b0) begin failures++; $display("FAIL race_pre got=%0d/%b exp=0/0", count, buzz); end
    cycle(0, 0, 1, 0, 0);
    checks++; if (shoot !== 1'b1 || buzz !== 1'b0) begin failures++; $display("FAIL race_shot got=%b/%b exp=1/0", shoot, buzz); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (buzz !== 1'b0 || poss !== 1'b1 || count !== 4'd10) begin failures++; $display("FAIL race_after got=%b/%b/%0d exp=0/1/10", buzz, poss, count); end
    idle(1);
    checks++; if (buzz !== 1'b0) begin failures++; $display("FAIL race_nobuzz got=%b exp=0", buzz); end
    cycle(0, 1, 0, 0, 0);
  endtask

  task test_saturation();
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0);
    end
    checks++; if (score_a !== (WIN ? 4'd9 : 4'd15)) begin failures++; $display("FAIL sat_score_a got=%0d exp=%0d", score_a, WIN ? 9 : 15); end
    checks++; if (score_b !== 4'd0) begin failures++; $display("FAIL sat_score_b got=%0d exp=0", score_b); end
    checks++; if (buzz !== WIN) begin failures++; $display("FAIL sat_buzz got=%b exp=%b", buzz, WIN); end
    checks++; if (count !== (WIN ? 4'd0 : 4'd10)) begin failures++; $display("FAIL sat_count got=%0d exp=%0d", count, WIN ? 0 : 10); end
    cycle(0, 1, 0, 0, 0);
    checks++; if (buzz !== 1'b0 || busy !== 1'b0 || score_a !== 4'd0) begin failures++; $display("FAIL sat_stop got=%b/%b/%0d exp=0/0/0", buzz, busy, score_a); end
  endtask

  task test_reset_mid_buzz();
    cycle(1, 0, 0, 0, 0);
    idle(45);
    checks++; if (buzz !== 1'b1) begin failures++; $display("FAIL rb_in_buzz got=%b exp=1", buzz); end
    #2 nrst = 1'b0;
    model_reset();
    #1;
    checks++; if ({count, shoot, buzz, poss, score_a, score_b, busy} !== 16'd0) begin failures++; $display("FAIL rb_async got=%h exp=0", {count, shoot, buzz, poss, score_a, score_b, busy}); end
    #2 nrst = 1'b1;
    idle(5);
    checks++; if (busy !== 1'b0 || buzz !== 1'b0 || shoot !== 1'b0) begin failures++; $display("FAIL rb_no_residual got=%b/%b/%b exp=0/0/0", busy, buzz, shoot); end
    cycle(1, 0, 0, 0, 0);
    idle(2);
    cycle(0, 1, 1, 0, 0);
    checks++; if ({count, shoot, buzz, poss, score_a, score_b, busy} !== 16'd0) begin failures++; $display("FAIL rb_stop got=%h exp=0", {count, shoot, buzz, poss, score_a, score_b, busy}); end
    cycle(1, 0, 0, 0, 0);
    checks++; if (count !== 4'd10 || poss !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rb_restart got=%0d/%b/%b exp=10/0/1", count, poss, busy); end
    cycle(0, 1, 0, 0, 0);
  endtask

  task test_random();
    logic       st, sp, sa, sb, h;
    logic [3:0] e_count;
    logic       e_buzz;
    for (int i = 0; i < 3000; i++) begin
      sp = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 3) == 0);
      sa = ($urandom_range(0, 5) == 0);
      sb = ($urandom_range(0, 5) == 0);
      h  = 1'($urandom_range(0, 1));
      cycle(st, sp, sa, sb, h);
      e_count = (!m_active || m_done) ? 4'd0 : (m_shot ? m_held : cnt_at(m_t));
      e_buzz  = m_active && (m_done || (!m_shot && m_t >= EXP));
      checks++; if (count !== e_count)   begin failures++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, e_count); end
      checks++; if (shoot !== m_shot)    begin failures++; $display("FAIL rnd_shoot i=%0d got=%b exp=%b", i, shoot, m_shot); end
      checks++; if (buzz !== e_buzz)     begin failures++; $display("FAIL rnd_buzz i=%0d got=%b exp=%b", i, buzz, e_buzz); end
      checks++; if (poss !== m_poss)     begin failures++; $display("FAIL rnd_poss i=%0d got=%b exp=%b", i, poss, m_poss); end
      checks++; if (score_a !== m_sa)    begin failures++; $display("FAIL rnd_score_a i=%0d got=%0d exp=%0d", i, score_a, m_sa); end
      checks++; if (score_b !== m_sb)    begin failures++; $display("FAIL rnd_score_b i=%0d got=%0d exp=%0d", i, score_b, m_sb); end
      checks++; if (busy !== m_active)   begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, m_active); end
      if ($urandom_range(0, 599) == 0) begin
        #2 nrst = 1'b0;
        model_reset();
        #1;
        checks++; if ({busy, buzz, shoot, count} !== 7'd0) begin failures++; $display("FAIL rnd_reset i=%0d got=%h exp=0", i, {busy, buzz, shoot, count}); end
        nrst = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_shot();
    test_expiry_race();
    test_saturation();
    test_reset_mid_buzz();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shot_ctrl.md
SHOT_CTRL -- requirements
Module: shot_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter SHOT_TIME, default 4'd10, the countdown value loaded at each possession start.
REQ-003 Parameter TICK_DIV, default 4, the number of clk cycles per countdown step (legal range 1..15).
REQ-004 Parameter BUZZ_LEN, default 3, the number of clk cycles buzz stays high on expiry (legal range 1..15).
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 nrst  in  1  asynchronous active-low reset.
REQ-007 start  in  1  level; in IDLE, begins play.
REQ-008 stop  in  1  level; returns the block to IDLE from any state, with priority over all other inputs.
REQ-009 shoot_a  in  1  team A shot request.
REQ-010 shoot_b  in  1  team B shot request.
REQ-011 hit  in  1  shot result, sampled only in SHOT.
REQ-012 count  out  4  remaining shot-clock value.
REQ-013 shoot  out  1  one-cycle pulse while in SHOT.
REQ-014 buzz  out  1  high while in BUZZ (and in DONE when configured).
REQ-015 poss  out  1  possession: 0 = team A, 1 = team B.
REQ-016 score_a  out  4  team A score.
REQ-017 score_b  out  4  team B score.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The state machine SHALL have the states IDLE, RUN, SHOT, BUZZ and DONE; DONE exists only under REQ-034.
REQ-020 IDLE->RUN on start=1: count=SHOT_TIME, divider=0, poss=0, scores cleared.
REQ-021 RUN: the divider SHALL count 0..TICK_DIV-1; at TICK_DIV-1, count==0 -> BUZZ, otherwise count decrements by 1 and the divider wraps to 0.
REQ-022 RUN: the possessor's request (shoot_a when poss=0, shoot_b when poss=1) SHALL cause RUN->SHOT on the next edge; the non-possessor's request SHALL be ignored.
REQ-023 SHOT SHALL last exactly one cycle, with shoot=1 and count held; hit=1 increments the possessor's score.
REQ-024 SHOT->RUN: poss inverts, count=SHOT_TIME, divider=0.
REQ-025 BUZZ SHALL last BUZZ_LEN cycles, with count=0 and shot requests ignored; on exit, poss inverts, count=SHOT_TIME, divider=0, and the next state is RUN.
REQ-026 If a possessor request and the expiry tick occur in the same cycle, the shot SHALL win (RUN->SHOT) and no buzz SHALL occur.
REQ-027 A request held high across states SHALL be re-evaluated in RUN; a held request fires again in the first RUN cycle if it belongs to the new possessor.
REQ-028 Scores SHALL saturate at 15 and never wrap.
REQ-029 stop=1 -> IDLE on the next edge; count, poss, scores and buzz SHALL clear, and shoot SHALL not pulse.
REQ-030 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 nrst=0 SHALL immediately force: state=IDLE, count=0, shoot=0, buzz=0, poss=0, score_a=0, score_b=0, busy=0, divider=0.
REQ-032 Reset asserted mid-RUN, SHOT or BUZZ SHALL abort the operation with no residual pulse after release.
REQ-033 After release the block SHALL stay in IDLE until start=1.

Configuration
REQ-034 With macro SHOT_CTRL_WIN_EN defined: when a score reaches 9 in SHOT, the block SHALL enter DONE instead of RUN; DONE holds buzz=1, count=0 and the scores, and exits only via stop or reset.
REQ-035 Without SHOT_CTRL_WIN_EN: there is no DONE state, play continues indefinitely, and scores saturate per REQ-028.

Verification
REQ-036 Defaults, start pulse, no shots -> count 10 steps to 0 every 4 cycles; buzz rises 44 cycles after RUN entry and stays high 3 cycles; then poss=1 and count=10.
REQ-037 poss=0, shoot_a=1 with hit=1 at count=7 -> one shoot pulse, score_a=1, poss=1, count=10; shoot_b asserted at the same time is ignored.
REQ-038 shoot_a on the exact cycle of the count==0 expiry tick -> SHOT taken, buzz stays 0, poss flips.
REQ-039 Sixteen made shots by team A (with team B missing) -> score_a stops at 15 without macro; with SHOT_CTRL_WIN_EN, score_a=9 leads to DONE with buzz=1 held until stop.
REQ-040 nrst pulsed low mid-BUZZ, then stop asserted in RUN -> all outputs 0 per REQ-031/029; start restarts with count=10, poss=0.
